// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI SRAM engine (mode 0) for the CPU datapath memory port.
// Define MEM_BURST_EN to keep CS low after a transfer for sequential-address bursts.
module spi_mem_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int CS_HIGH    = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int FW   = 9 + ADDR_WIDTH + DATA_WIDTH;
    localparam int BW   = $clog2(FW);
    localparam int DMAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int CW   = $clog2(DMAX + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] REC_END  = CW'(CS_HIGH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);

`ifdef MEM_BURST_EN
    localparam logic [BW-1:0] DATA_BIT = BW'(FW - DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, RECOVER, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, RECOVER} state_t;
`endif

    state_t                state;
    logic [FW-1:0]         shreg;
    logic [FW-1:0]         frame;
    logic [DATA_WIDTH-1:0] rx;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic                  is_write;

    // Wire bit 15 of the address is forced to 0: only 32 KiB reachable.
    assign frame = {(we ? 8'h02 : 8'h03), 1'b0, addr,
                    wdata & {DATA_WIDTH{we}}};

`ifdef MEM_BURST_EN
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  pending;
    logic                  seq;

    // Widened compare so the top address never continues into a wrap.
    assign seq = (we == is_write) &&
                 ({1'b0, addr} ==
                  {1'b0, last_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1});
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            rx       <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            is_write <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
`ifdef MEM_BURST_EN
            last_addr <= '0;
            pending   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        shreg    <= frame;
                        spi_mosi <= frame[FW-1];
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        is_write <= we;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= SHIFT;
`ifdef MEM_BURST_EN
                        last_addr <= addr;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt != DIV_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[DATA_WIDTH-2:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_idx == LAST_BIT) begin
                                done     <= 1'b1;
                                spi_mosi <= 1'b0;
                                if (!is_write) rdata <= rx;
`ifdef MEM_BURST_EN
                                busy  <= 1'b0;
                                state <= HOLD;
`else
                                spi_cs_n <= 1'b1;
                                state    <= RECOVER;
`endif
                            end else begin
                                shreg    <= {shreg[FW-2:0], 1'b0};
                                spi_mosi <= shreg[FW-2];
                                bit_idx  <= bit_idx + 1'b1;
                            end
                        end
                    end
                end
                RECOVER: begin
                    if (cnt != REC_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
`ifdef MEM_BURST_EN
                        if (pending) begin
                            pending  <= 1'b0;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= shreg[FW-1];
                            bit_idx  <= '0;
                            state    <= SHIFT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
`ifdef MEM_BURST_EN
                HOLD: begin
                    if (req) begin
                        is_write  <= we;
                        last_addr <= addr;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        if (seq) begin
                            // Memory auto-increments: send only the data byte.
                            shreg <= {wdata & {DATA_WIDTH{we}},
                                      {(FW - DATA_WIDTH){1'b0}}};
                            spi_mosi <= we & wdata[DATA_WIDTH-1];
                            bit_idx  <= DATA_BIT;
                            state    <= SHIFT;
                        end else begin
                            shreg    <= frame;
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            pending  <= 1'b1;
                            state    <= RECOVER;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl with a behavioural SPI SRAM slave.
// Works with or without MEM_BURST_EN defined.
module tb_spi_mem_ctrl;

    localparam int CLK_DIV = 2;
    localparam int CS_HIGH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int errors = 0;

    spi_mem_ctrl #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    logic [7:0] seed;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h1234:  return 8'hA5;
            'h0100:  return 8'h11;
            'h0101:  return 8'h22;
            default: return 8'(a * 13 + (a >> 7)) ^ seed;
        endcase
    endfunction

    // Slave memory: writes that arrived over the wire
    logic [7:0] slv_wr [int];
    // Bench's own expectation of memory contents
    logic [7:0] ref_wr [int];

    function automatic logic [7:0] slave_byte(input int a);
        return slv_wr.exists(a) ? slv_wr[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        return ref_wr.exists(a) ? ref_wr[a] : init_byte(a);
    endfunction

    int          mbits;
    logic [31:0] mhdr;
    logic [7:0]  mbyte;
    logic [7:0]  mcmd;
    logic [15:0] maddr;
    logic [7:0]  wire_q[$];
    int          pulses = 0;
    int          done_cnt = 0;
    logic [7:0]  mb;
    int          moff;

    // Sequential-mode SRAM: header of cmd + 16-bit address, then data bytes
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mbits = 0;
        end else begin
            mhdr  = {mhdr[30:0], spi_mosi};
            mbyte = {mbyte[6:0], spi_mosi};
            mbits++;
            if (mbits == 24) begin
                mcmd  = mhdr[23:16];
                maddr = mhdr[15:0];
            end
            if (mbits % 8 == 0) begin
                wire_q.push_back(mbyte);
                if (mbits >= 32 && mcmd == 8'h02)
                    slv_wr[int'(maddr + 16'((mbits - 32) / 8))] = mbyte;
            end
        end
    end

    always @(negedge spi_sclk or negedge spi_cs_n) begin
        if (!spi_cs_n && mbits >= 24 && mcmd == 8'h03) begin
            moff = mbits - 24;
            mb = slave_byte(int'(maddr + 16'(moff / 8)));
            spi_miso <= mb[7 - (moff % 8)];
        end else begin
            spi_miso <= 1'b0;
        end
    end

    always @(posedge spi_sclk) pulses++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  exp_rdata;
    logic        hold_valid;
    logic        hold_we;
    logic [14:0] hold_addr;

    task automatic txn(input logic w, input logic [14:0] a,
                       input logic [7:0] d, input logic noise);
        int p0, q0, dc0, lat, hi, n;
        logic cont, mism, got;
        logic [7:0] eb [4];
        cont = 1'b0;
        mism = 1'b0;
`ifdef MEM_BURST_EN
        if (hold_valid) begin
            cont = (w == hold_we) && (int'(a) == int'(hold_addr) + 1);
            mism = !cont;
        end
`endif
        n = cont ? 1 : 4;
        if (cont) begin
            eb[0] = w ? d : 8'h00;
        end else begin
            eb[0] = w ? 8'h02 : 8'h03;
            eb[1] = {1'b0, a[14:8]};
            eb[2] = a[7:0];
            eb[3] = w ? d : 8'h00;
        end
        @(negedge clk);
        for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
        chk("idle_before_req", 32'(busy), 32'd0);
        p0 = pulses;
        q0 = wire_q.size();
        dc0 = done_cnt;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        we = 1'($urandom); addr = 15'($urandom); wdata = 8'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (!mism) chk("cs_low_after_accept", 32'(spi_cs_n), 32'd0);
        hi = spi_cs_n ? 1 : 0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 2000 && !got; k++) begin
            req = noise && k >= 5 && k <= 20;
            @(posedge clk); #1;
            if (spi_cs_n && !done) hi++;
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
        req = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (!mism)
            chk("done_latency", 32'(lat), 32'(cont ? 16 * CLK_DIV : 64 * CLK_DIV));
        else
            chk("cs_high_gap", 32'(hi >= CS_HIGH), 32'd1);
        if (w) ref_wr[int'(a)] = d;
        else exp_rdata = ref_byte(int'(a));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("sclk_pulses", 32'(pulses - p0), 32'(cont ? 8 : 32));
        chk("wire_bytes", 32'(wire_q.size() - q0), 32'(n));
        for (int i = 0; i < n; i++)
            if (q0 + i < wire_q.size())
                chk("mosi_byte", 32'(wire_q[q0 + i]), 32'(eb[i]));
`ifdef MEM_BURST_EN
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_cs", 32'(spi_cs_n), 32'd0);
        @(posedge clk); #1;
        hold_valid = 1'b1;
        hold_we = w;
        hold_addr = a;
`else
        for (int i = 0; i < CS_HIGH; i++) begin
            chk("recover_busy", 32'(busy), 32'd1);
            chk("recover_cs", 32'(spi_cs_n), 32'd1);
            chk("recover_mosi", 32'(spi_mosi), 32'd0);
            @(posedge clk); #1;
        end
        chk("idle_busy", 32'(busy), 32'd0);
`endif
        chk("done_pulse_once", 32'(done_cnt - dc0), 32'd1);
        chk("done_low", 32'(done), 32'd0);
    endtask

    initial begin
        logic        pw;
        logic [14:0] pa;
        seed = 8'($urandom);
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        exp_rdata = 8'h00;
        hold_valid = 1'b0; hold_we = 1'b0; hold_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_cs", 32'(spi_cs_n), 32'd1);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        reset = 1'b1;

        txn(1'b0, 15'h1234, 8'h00, 1'b0);
        txn(1'b1, 15'h7FFF, 8'h3C, 1'b0);
        chk("slave_mem_7fff", 32'(slave_byte('h7FFF)), 32'h3C);
        txn(1'b0, 15'h0ABC, 8'h00, 1'b1);

        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 15'h0555;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (40) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(spi_cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(spi_sclk), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        chk("mid_rst_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_rdata = 8'h00;
        hold_valid = 1'b0;
        txn(1'b0, 15'h0010, 8'h00, 1'b0);

        txn(1'b0, 15'h0100, 8'h00, 1'b0);
        txn(1'b0, 15'h0101, 8'h00, 1'b0);
        txn(1'b0, 15'h0200, 8'h00, 1'b0);
        txn(1'b1, 15'h0201, 8'h5A, 1'b0);
        txn(1'b0, 15'h0201, 8'h00, 1'b0);

        pw = 1'b0;
        pa = 15'h0201;
        for (int i = 0; i < 24; i++) begin
            logic        w;
            logic [14:0] a;
            if ($urandom_range(2) == 0) begin
                w = pw;
                a = pa + 15'd1;
            end else begin
                w = 1'($urandom);
                a = 15'($urandom);
            end
            txn(w, a, 8'($urandom), 1'($urandom));
            pw = w;
            pa = a;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
